// File: rtl/status_array_arbiter.sv
// Arbitrates fetch lookups and refill updates into one registered status-array issue slot,
// then routes array responses back by requester ID. Optional guard: STATUS_ARB_STARVE_GUARD_EN.
module status_array_arbiter #(
  parameter int unsigned TAG_WIDTH    = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  // Mirrors shared_params.vh so the block stands alone.
  localparam int unsigned ADDR_WIDTH  = 6,
  localparam int unsigned ROW_WIDTH   = 16,
  localparam int unsigned NUM_BLOCKS  = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic [TAG_WIDTH-1:0]  i_lkp_tag,
  input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
  input  logic                  i_lkp_valid,
  output logic                  o_lkp_ready,
  input  logic [TAG_WIDTH-1:0]  i_upd_tag,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [ROW_WIDTH-1:0]  i_upd_data,
  input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  output logic [TAG_WIDTH:0]    o_sa_tag,
  output logic [ADDR_WIDTH-1:0] o_sa_addr,
  output logic [ROW_WIDTH-1:0]  o_sa_data,
  output logic                  o_sa_wen,
  output logic [NUM_BLOCKS-1:0] o_sa_wmask,
  output logic                  o_sa_valid,
  input  logic                  i_sa_ready,
  input  logic [TAG_WIDTH:0]    i_sa_tag,
  input  logic [ROW_WIDTH-1:0]  i_sa_data,
  input  logic                  i_sa_valid,
  output logic [TAG_WIDTH-1:0]  o_lkp_rsp_tag,
  output logic [ROW_WIDTH-1:0]  o_lkp_rsp_data,
  output logic                  o_lkp_rsp_valid,
  output logic [TAG_WIDTH-1:0]  o_upd_done_tag,
  output logic                  o_upd_done
);

  logic [TAG_WIDTH:0]    sa_tag_q, sa_tag_d;
  logic [ADDR_WIDTH-1:0] sa_addr_q, sa_addr_d;
  logic [ROW_WIDTH-1:0]  sa_data_q, sa_data_d;
  logic                  sa_wen_q, sa_wen_d;
  logic [NUM_BLOCKS-1:0] sa_wmask_q, sa_wmask_d;
  logic                  sa_valid_q, sa_valid_d;
  logic [TAG_WIDTH-1:0]  lkp_rsp_tag_q, lkp_rsp_tag_d;
  logic [ROW_WIDTH-1:0]  lkp_rsp_data_q, lkp_rsp_data_d;
  logic                  lkp_rsp_valid_q, lkp_rsp_valid_d;
  logic [TAG_WIDTH-1:0]  upd_done_tag_q, upd_done_tag_d;
  logic                  upd_done_q, upd_done_d;

  logic acc, force_lkp, upd_gnt, lkp_gnt;

  assign acc       = ~i_halt & (~sa_valid_q | i_sa_ready);
  assign upd_gnt   = acc & i_upd_valid & ~(force_lkp & i_lkp_valid);
  assign lkp_gnt   = acc & i_lkp_valid & ~upd_gnt;
  assign o_upd_ready = upd_gnt;
  assign o_lkp_ready = lkp_gnt;

`ifdef STATUS_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_lkp = (starve_cnt_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_halt) begin
      if (!i_lkp_valid || lkp_gnt) starve_cnt_d = 4'd0;
      else if (upd_gnt)            starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) starve_cnt_q <= 4'd0;
    else         starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict update priority; the term only keeps the parameter referenced.
  assign force_lkp = 1'b0 && (STARVE_LIMIT != 0);
`endif

  always_comb begin
    sa_tag_d   = sa_tag_q;
    sa_addr_d  = sa_addr_q;
    sa_data_d  = sa_data_q;
    sa_wen_d   = sa_wen_q;
    sa_wmask_d = sa_wmask_q;
    sa_valid_d = sa_valid_q;
    if (upd_gnt) begin
      sa_tag_d   = {1'b1, i_upd_tag};
      sa_addr_d  = i_upd_addr;
      sa_data_d  = i_upd_data;
      sa_wen_d   = 1'b1;
      sa_wmask_d = i_upd_wmask;
      sa_valid_d = 1'b1;
    end else if (lkp_gnt) begin
      sa_tag_d   = {1'b0, i_lkp_tag};
      sa_addr_d  = i_lkp_addr;
      sa_data_d  = '0;
      sa_wen_d   = 1'b0;
      sa_wmask_d = '0;
      sa_valid_d = 1'b1;
    end else if (!i_halt && i_sa_ready) begin
      sa_valid_d = 1'b0;
    end
  end

  always_comb begin
    lkp_rsp_tag_d   = lkp_rsp_tag_q;
    lkp_rsp_data_d  = lkp_rsp_data_q;
    lkp_rsp_valid_d = lkp_rsp_valid_q;
    upd_done_tag_d  = upd_done_tag_q;
    upd_done_d      = upd_done_q;
    if (!i_halt) begin
      lkp_rsp_valid_d = i_sa_valid & ~i_sa_tag[TAG_WIDTH];
      upd_done_d      = i_sa_valid & i_sa_tag[TAG_WIDTH];
      if (lkp_rsp_valid_d) begin
        lkp_rsp_tag_d  = i_sa_tag[TAG_WIDTH-1:0];
        lkp_rsp_data_d = i_sa_data;
      end
      if (upd_done_d) upd_done_tag_d = i_sa_tag[TAG_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      sa_tag_q        <= '0;
      sa_addr_q       <= '0;
      sa_data_q       <= '0;
      sa_wen_q        <= 1'b0;
      sa_wmask_q      <= '0;
      sa_valid_q      <= 1'b0;
      lkp_rsp_tag_q   <= '0;
      lkp_rsp_data_q  <= '0;
      lkp_rsp_valid_q <= 1'b0;
      upd_done_tag_q  <= '0;
      upd_done_q      <= 1'b0;
    end else begin
      sa_tag_q        <= sa_tag_d;
      sa_addr_q       <= sa_addr_d;
      sa_data_q       <= sa_data_d;
      sa_wen_q        <= sa_wen_d;
      sa_wmask_q      <= sa_wmask_d;
      sa_valid_q      <= sa_valid_d;
      lkp_rsp_tag_q   <= lkp_rsp_tag_d;
      lkp_rsp_data_q  <= lkp_rsp_data_d;
      lkp_rsp_valid_q <= lkp_rsp_valid_d;
      upd_done_tag_q  <= upd_done_tag_d;
      upd_done_q      <= upd_done_d;
    end
  end

  assign o_sa_tag        = sa_tag_q;
  assign o_sa_addr       = sa_addr_q;
  assign o_sa_data       = sa_data_q;
  assign o_sa_wen        = sa_wen_q;
  assign o_sa_wmask      = sa_wmask_q;
  assign o_sa_valid      = sa_valid_q;
  assign o_lkp_rsp_tag   = lkp_rsp_tag_q;
  assign o_lkp_rsp_data  = lkp_rsp_data_q;
  assign o_lkp_rsp_valid = lkp_rsp_valid_q;
  assign o_upd_done_tag  = upd_done_tag_q;
  assign o_upd_done      = upd_done_q;

endmodule

// File: tb/tb_status_array_arbiter.sv
// Directed bench for status_array_arbiter: reset, issue, priority, stall, halt, starvation order.
module tb_status_array_arbiter;

  localparam int unsigned TW = 1;
  localparam int unsigned AW = 6;
  localparam int unsigned RW = 16;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_halt = 1'b0;
  logic [TW-1:0] i_lkp_tag = '0;
  logic [AW-1:0] i_lkp_addr = '0;
  logic          i_lkp_valid = 1'b0;
  logic          o_lkp_ready;
  logic [TW-1:0] i_upd_tag = '0;
  logic [AW-1:0] i_upd_addr = '0;
  logic [RW-1:0] i_upd_data = '0;
  logic [NB-1:0] i_upd_wmask = '0;
  logic          i_upd_valid = 1'b0;
  logic          o_upd_ready;
  logic [TW:0]   o_sa_tag;
  logic [AW-1:0] o_sa_addr;
  logic [RW-1:0] o_sa_data;
  logic          o_sa_wen;
  logic [NB-1:0] o_sa_wmask;
  logic          o_sa_valid;
  logic          i_sa_ready = 1'b0;
  logic [TW:0]   i_sa_tag = '0;
  logic [RW-1:0] i_sa_data = '0;
  logic          i_sa_valid = 1'b0;
  logic [TW-1:0] o_lkp_rsp_tag;
  logic [RW-1:0] o_lkp_rsp_data;
  logic          o_lkp_rsp_valid;
  logic [TW-1:0] o_upd_done_tag;
  logic          o_upd_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  status_array_arbiter #(.TAG_WIDTH(TW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_lkp_tag(i_lkp_tag), .i_lkp_addr(i_lkp_addr), .i_lkp_valid(i_lkp_valid),
    .o_lkp_ready(o_lkp_ready),
    .i_upd_tag(i_upd_tag), .i_upd_addr(i_upd_addr), .i_upd_data(i_upd_data),
    .i_upd_wmask(i_upd_wmask), .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready),
    .o_sa_tag(o_sa_tag), .o_sa_addr(o_sa_addr), .o_sa_data(o_sa_data), .o_sa_wen(o_sa_wen),
    .o_sa_wmask(o_sa_wmask), .o_sa_valid(o_sa_valid), .i_sa_ready(i_sa_ready),
    .i_sa_tag(i_sa_tag), .i_sa_data(i_sa_data), .i_sa_valid(i_sa_valid),
    .o_lkp_rsp_tag(o_lkp_rsp_tag), .o_lkp_rsp_data(o_lkp_rsp_data),
    .o_lkp_rsp_valid(o_lkp_rsp_valid), .o_upd_done_tag(o_upd_done_tag), .o_upd_done(o_upd_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with a lookup pending.
    i_lkp_valid = 1'b1; i_lkp_tag = 1'b1; i_lkp_addr = 6'd5;
    tick();
    chk("rst_sa_valid", 32'(o_sa_valid), 32'd0);
    chk("rst_sa_tag", 32'(o_sa_tag), 32'd0);
    chk("rst_sa_addr", 32'(o_sa_addr), 32'd0);
    chk("rst_sa_wen", 32'(o_sa_wen), 32'd0);
    chk("rst_rsp_valid", 32'(o_lkp_rsp_valid), 32'd0);
    chk("rst_upd_done", 32'(o_upd_done), 32'd0);
    chk("rst_rsp_data", 32'(o_lkp_rsp_data), 32'd0);

    // First accept on the first edge out of reset.
    arst_n = 1'b1;
    tick();
    chk("lkp_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("lkp_sa_tag", 32'(o_sa_tag), 32'h1);
    chk("lkp_sa_addr", 32'(o_sa_addr), 32'd5);
    chk("lkp_sa_wen", 32'(o_sa_wen), 32'd0);

    // Drain and return a lookup response.
    i_lkp_valid = 1'b0; i_sa_ready = 1'b1;
    i_sa_valid = 1'b1; i_sa_tag = 2'b01; i_sa_data = 16'h000A;
    tick();
    chk("drain_sa_valid", 32'(o_sa_valid), 32'd0);
    chk("rsp_valid", 32'(o_lkp_rsp_valid), 32'd1);
    chk("rsp_tag", 32'(o_lkp_rsp_tag), 32'd1);
    chk("rsp_data", 32'(o_lkp_rsp_data), 32'hA);
    chk("rsp_no_done", 32'(o_upd_done), 32'd0);
    i_sa_valid = 1'b0;
    tick();
    chk("rsp_pulse_end", 32'(o_lkp_rsp_valid), 32'd0);
    chk("rsp_data_hold", 32'(o_lkp_rsp_data), 32'hA);

    // Update and lookup together: update first.
    i_upd_valid = 1'b1; i_upd_tag = 1'b0; i_upd_addr = 6'd9;
    i_upd_data = 16'h1234; i_upd_wmask = 4'b0101;
    i_lkp_valid = 1'b1; i_lkp_tag = 1'b0; i_lkp_addr = 6'd3;
    #1;
    chk("prio_upd_ready", 32'(o_upd_ready), 32'd1);
    chk("prio_lkp_ready", 32'(o_lkp_ready), 32'd0);
    tick();
    chk("upd_sa_tag", 32'(o_sa_tag), 32'h2);
    chk("upd_sa_wen", 32'(o_sa_wen), 32'd1);
    chk("upd_sa_addr", 32'(o_sa_addr), 32'd9);
    chk("upd_sa_data", 32'(o_sa_data), 32'h1234);
    chk("upd_sa_wmask", 32'(o_sa_wmask), 32'h5);
    i_upd_valid = 1'b0;
    tick();
    chk("lkp2_sa_tag", 32'(o_sa_tag), 32'h0);
    chk("lkp2_sa_wen", 32'(o_sa_wen), 32'd0);
    chk("lkp2_sa_addr", 32'(o_sa_addr), 32'd3);
    chk("lkp2_sa_data", 32'(o_sa_data), 32'h0);
    chk("lkp2_sa_wmask", 32'(o_sa_wmask), 32'h0);
    i_lkp_valid = 1'b0;
    i_sa_valid = 1'b1; i_sa_tag = 2'b11; i_sa_data = 16'hBEEF;
    tick();
    chk("done_pulse", 32'(o_upd_done), 32'd1);
    chk("done_tag", 32'(o_upd_done_tag), 32'd1);
    chk("done_no_rsp", 32'(o_lkp_rsp_valid), 32'd0);
    chk("done_rsp_data_hold", 32'(o_lkp_rsp_data), 32'hA);
    chk("done_sa_drained", 32'(o_sa_valid), 32'd0);
    i_sa_valid = 1'b0;

    // Array not ready: one update enters the empty slot and is held.
    i_sa_ready = 1'b0;
    i_upd_valid = 1'b1; i_upd_tag = 1'b1; i_upd_addr = 6'd7; i_upd_data = 16'h5555;
    i_lkp_valid = 1'b1; i_lkp_addr = 6'd2;
    tick();
    chk("stall_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("stall_sa_tag", 32'(o_sa_tag), 32'h3);
    chk("done_pulse_end", 32'(o_upd_done), 32'd0);
    i_upd_addr = 6'd8; i_upd_data = 16'h6666;
    for (int i = 0; i < 5; i++) begin
      chk("stall_upd_ready", 32'(o_upd_ready), 32'd0);
      chk("stall_lkp_ready", 32'(o_lkp_ready), 32'd0);
      tick();
      chk("stall_sa_addr", 32'(o_sa_addr), 32'd7);
      chk("stall_sa_data", 32'(o_sa_data), 32'h5555);
    end
    i_sa_ready = 1'b1;
    #1;
    chk("unstall_upd_ready", 32'(o_upd_ready), 32'd1);
    tick();
    chk("nobubble_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("nobubble_sa_addr", 32'(o_sa_addr), 32'd8);
    chk("nobubble_sa_tag", 32'(o_sa_tag), 32'h3);
    i_upd_valid = 1'b0;
    tick();
    chk("after_stall_lkp_addr", 32'(o_sa_addr), 32'd2);
    chk("after_stall_lkp_tag", 32'(o_sa_tag), 32'h0);

    // Halt freezes the slot even with the array ready.
    i_halt = 1'b1; i_lkp_valid = 1'b0;
    i_upd_valid = 1'b1; i_upd_addr = 6'd11; i_upd_tag = 1'b0;
    #1;
    chk("halt_upd_ready", 32'(o_upd_ready), 32'd0);
    tick();
    tick();
    chk("halt_sa_valid", 32'(o_sa_valid), 32'd1);
    chk("halt_sa_addr", 32'(o_sa_addr), 32'd2);
    i_halt = 1'b0;
    #1;
    chk("release_upd_ready", 32'(o_upd_ready), 32'd1);
    tick();
    chk("release_sa_addr", 32'(o_sa_addr), 32'd11);
    chk("release_sa_tag", 32'(o_sa_tag), 32'h2);

    // Continuous contention: grant order by lookup-ID bit of the issued tag.
    i_lkp_valid = 1'b1; i_lkp_addr = 6'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
`ifdef STATUS_ARB_STARVE_GUARD_EN
      chk("starve_order_msb", 32'(o_sa_tag[TW]), (i % 5 == 4) ? 32'd0 : 32'd1);
`else
      chk("strict_order_msb", 32'(o_sa_tag[TW]), 32'd1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
